// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin write arbiter for a 32x32 register file.
// After reset it can sweep registers 1..31 to zero before accepting requests.
module regfile_wr_arbiter #(
    parameter int unsigned CLEAR_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam state_t START_STATE = (CLEAR_EN != 0) ? CLEAR : RUN;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        we3_q, we3_d;
    logic [4:0]  wa3_q, wa3_d;
    logic [31:0] wd3_q, wd3_d;
    logic        run;
    logic        gnt1;

    // rst gates the combinational outputs too, so a RUN reset state cannot leak a ready.
    always_comb begin
        run        = (state_q == RUN) && !rst;
        gnt1       = req1_valid && (!req0_valid || ptr_q);
        req0_ready = run && req0_valid && !gnt1;
        req1_ready = run && gnt1;
        init_done  = run;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we3_d   = 1'b0;
        wa3_d   = wa3_q;
        wd3_d   = wd3_q;
        case (state_q)
            CLEAR: begin
                // Leave only after the address-31 write has been presented for a full cycle.
                if (we3_q && (wa3_q == 5'd31)) begin
                    state_d = RUN;
                end else begin
                    we3_d = 1'b1;
                    wa3_d = cnt_q;
                    wd3_d = '0;
                    if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                if (req0_ready) begin
                    ptr_d = 1'b1;
                    if (req0_addr != 5'd0) begin
                        we3_d = 1'b1;
                        wa3_d = req0_addr;
                        wd3_d = req0_data;
                    end
                end else if (req1_ready) begin
                    ptr_d = 1'b0;
                    if (req1_addr != 5'd0) begin
                        we3_d = 1'b1;
                        wa3_d = req1_addr;
                        wd3_d = req1_data;
                    end
                end
            end
            default: state_d = START_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START_STATE;
            cnt_q   <= 5'd1;
            ptr_q   <= 1'b0;
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

endmodule
